// File: rtl/fetch_decode_skid_if.sv
// Fetch-to-decode handshake bundle: fetch payload in, decode payload out, stall counter.
interface fetch_decode_skid_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] InstrF;
  logic [ADDR_WIDTH-1:0] PCF;
  logic [ADDR_WIDTH-1:0] PCPlus4F;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [ADDR_WIDTH-1:0] PCD;
  logic [ADDR_WIDTH-1:0] PCPlus4D;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  // Environment side: fetch producer and decode consumer
  modport master (
    output flush, in_valid, InstrF, PCF, PCPlus4F, out_ready,
    input  in_ready, out_valid, InstrD, PCD, PCPlus4D, stall_cnt
  );

  // Pipeline stage side
  modport slave (
    input  flush, in_valid, InstrF, PCF, PCPlus4F, out_ready,
    output in_ready, out_valid, InstrD, PCD, PCPlus4D, stall_cnt
  );
endinterface

// File: rtl/fetch_decode_skid.sv
// Fetch/decode pipeline register with a one-entry skid buffer so in_ready never
// depends combinationally on out_ready. Decode outputs come straight from flops.
module fetch_decode_skid #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013),
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input logic                  clk,
  input logic                  reset,
  fetch_decode_skid_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0] main_instr_q, main_instr_d;
  logic [ADDR_WIDTH-1:0] main_pc_q, main_pc_d;
  logic [ADDR_WIDTH-1:0] main_pcp4_q, main_pcp4_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [ADDR_WIDTH-1:0] skid_pcp4_q, skid_pcp4_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic                  in_xfer;
  logic                  out_xfer;

  // Next-state, payload steering and stall counting
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    main_pcp4_d  = main_pcp4_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_pcp4_d  = skid_pcp4_q;
    stall_cnt_d  = stall_cnt_q;
    in_xfer      = bus.in_valid & in_ready_q;
    out_xfer     = out_valid_q & bus.out_ready;

    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_instr_d = bus.InstrF;
          main_pc_d    = bus.PCF;
          main_pcp4_d  = bus.PCPlus4F;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_instr_d = bus.InstrF;
          main_pc_d    = bus.PCF;
          main_pcp4_d  = bus.PCPlus4F;
        end else if (in_xfer) begin
          skid_instr_d = bus.InstrF;
          skid_pc_d    = bus.PCF;
          skid_pcp4_d  = bus.PCPlus4F;
          state_d      = TWO;
        end else if (out_xfer) begin
          main_instr_d = NOP_INSTR;
          main_pc_d    = '0;
          main_pcp4_d  = '0;
          state_d      = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_instr_d = skid_instr_q;
          main_pc_d    = skid_pc_q;
          main_pcp4_d  = skid_pcp4_q;
          state_d      = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Branch redirect discards everything held, including this cycle's offer
    if (bus.flush) begin
      state_d      = EMPTY;
      main_instr_d = NOP_INSTR;
      main_pc_d    = '0;
      main_pcp4_d  = '0;
    end

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);

    if (out_valid_q && !bus.out_ready && !bus.flush && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Control, decode-visible payload and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      main_pcp4_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      main_pcp4_q  <= main_pcp4_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Skid payload is only meaningful while in TWO, so it carries no reset
  always_ff @(posedge clk) begin
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
    skid_pcp4_q  <= skid_pcp4_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.InstrD    = main_instr_q;
  assign bus.PCD       = main_pc_q;
  assign bus.PCPlus4D  = main_pcp4_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_decode_skid.sv
// Bench for fetch_decode_skid: directed table, corner sequences and a random run
// against a queue-based reference model. A 4-bit-counter copy shares all inputs.
module tb_fetch_decode_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pcp4_f;

  int unsigned tests;
  int unsigned fails;

  fetch_decode_skid_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();
  fetch_decode_skid_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(4))  bus_s ();

  assign bus.flush      = flush;
  assign bus.in_valid   = in_valid;
  assign bus.out_ready  = out_ready;
  assign bus.InstrF     = instr_f;
  assign bus.PCF        = pc_f;
  assign bus.PCPlus4F   = pcp4_f;
  assign bus_s.flush    = flush;
  assign bus_s.in_valid = in_valid;
  assign bus_s.out_ready = out_ready;
  assign bus_s.InstrF   = instr_f;
  assign bus_s.PCF      = pc_f;
  assign bus_s.PCPlus4F = pcp4_f;

  fetch_decode_skid #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NOP_INSTR(NOP), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  fetch_decode_skid #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NOP_INSTR(NOP), .CNT_WIDTH(4)) dut_s (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO of at most two entries plus an unbounded stall tally
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } ent_t;

  ent_t        mq[$];
  int unsigned mcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] ei, ep, ep4;
    int unsigned sc;
    ei  = (mq.size() > 0) ? mq[0].instr : NOP;
    ep  = (mq.size() > 0) ? mq[0].pc    : 32'h0;
    ep4 = (mq.size() > 0) ? mq[0].pcp4  : 32'h0;
    sc  = (mcnt > 15) ? 15 : mcnt;
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("in_ready",  64'(bus.in_ready),  64'(mq.size() < 2));
    chk("InstrD",    64'(bus.InstrD),    64'(ei));
    chk("PCD",       64'(bus.PCD),       64'(ep));
    chk("PCPlus4D",  64'(bus.PCPlus4D),  64'(ep4));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(mcnt));
    chk("stall_cnt_w4", 64'(bus_s.stall_cnt), 64'(sc));
  endtask

  // One clock: drive inputs, probe in_ready for out_ready sensitivity, clock, update model, check
  task automatic cycle(input logic r, input logic f, input logic iv, input logic orr,
                       input logic [31:0] instr);
    logic ir_probe;
    logic ov_m, ir_m;
    ent_t e;
    rst_n    = r;
    flush    = f;
    in_valid = iv;
    instr_f  = instr;
    pc_f     = {instr[29:0], 2'b00};
    pcp4_f   = {instr[29:0], 2'b00} + 32'd4;
    out_ready = ~orr;
    #1;
    ir_probe  = bus.in_ready;
    out_ready = orr;
    #1;
    chk("in_ready_vs_out_ready", 64'(bus.in_ready), 64'(ir_probe));
    e.instr = instr_f;
    e.pc    = pc_f;
    e.pcp4  = pcp4_f;
    @(posedge clk);
    ov_m = (mq.size() > 0);
    ir_m = (mq.size() < 2);
    if (!r) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (ov_m && !orr && !f && mcnt < 65535) mcnt++;
      if (f) begin
        mq.delete();
      end else begin
        if (ov_m && orr) void'(mq.pop_front());
        if (iv && ir_m) mq.push_back(e);
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  typedef struct {
    logic        iv;
    logic        orr;
    logic [31:0] instr;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_instr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tests = 0;
    fails = 0;
    mcnt  = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr_f = '0; pc_f = '0; pcp4_f = '0;

    // Streaming then backpressure; expectations are the outputs after each edge
    tbl[0] = '{1'b1, 1'b1, 32'hA000_0001, 1'b1, 1'b1, 32'hA000_0001, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 32'hB000_0002, 1'b1, 1'b1, 32'hB000_0002, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 32'hC000_0003, 1'b1, 1'b1, 32'hC000_0003, 16'd0};
    tbl[3] = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b1, NOP,           16'd0};
    tbl[4] = '{1'b1, 1'b0, 32'hA000_00A0, 1'b1, 1'b1, 32'hA000_00A0, 16'd0};
    tbl[5] = '{1'b1, 1'b0, 32'hB000_00B0, 1'b1, 1'b0, 32'hA000_00A0, 16'd1};
    tbl[6] = '{1'b1, 1'b0, 32'hC000_00C0, 1'b1, 1'b0, 32'hA000_00A0, 16'd2};
    tbl[7] = '{1'b1, 1'b1, 32'hC000_00C0, 1'b1, 1'b1, 32'hB000_00B0, 16'd2};
    tbl[8] = '{1'b1, 1'b1, 32'hC000_00C0, 1'b1, 1'b1, 32'hC000_00C0, 16'd2};
    tbl[9] = '{1'b0, 1'b1, 32'h0,         1'b0, 1'b1, NOP,           16'd2};

    @(negedge clk);
    do_reset();
    do_reset();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_InstrD",    64'(bus.InstrD),    64'(NOP));
    chk("rst_PCD",       64'(bus.PCD),       64'd0);
    chk("rst_PCPlus4D",  64'(bus.PCPlus4D),  64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);

    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, tbl[i].iv, tbl[i].orr, tbl[i].instr);
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_in_ready", i),  64'(bus.in_ready),  64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_InstrD", i),    64'(bus.InstrD),    64'(tbl[i].e_instr));
      chk($sformatf("tbl%0d_stall_cnt", i), 64'(bus.stall_cnt), 64'(tbl[i].e_cnt));
    end

    // Flush while TWO with an offer pending
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h1111_0001);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h1111_0002);
    chk("two_in_ready", 64'(bus.in_ready), 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'hDDDD_0001);
    chk("flush2_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush2_InstrD",    64'(bus.InstrD),    64'(NOP));
    chk("flush2_in_ready",  64'(bus.in_ready),  64'd1);
    // Flush in ONE with an acceptable offer: the offer must vanish
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h2222_0001);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hDDDD_0002);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("flush1_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush1_InstrD",    64'(bus.InstrD),    64'(NOP));

    // Counter saturation
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h3333_0001);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    chk("sat_w4",  64'(bus_s.stall_cnt), 64'd15);
    chk("sat_w16", 64'(bus.stall_cnt),   64'd20);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    chk("sat_w4_hold", 64'(bus_s.stall_cnt), 64'd15);

    // Reset while TWO with stall_cnt=7
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h4444_0001);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h4444_0002);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_cnt",      64'(bus.stall_cnt), 64'd7);
    chk("pre_rst_in_ready", 64'(bus.in_ready),  64'd0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h4444_0003);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("midrst_PCD",       64'(bus.PCD),       64'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0),
            $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_decode_skid.md
FETCH_DECODE_SKID -- requirements
Module: fetch_decode_skid

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning instruction width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning PC width in bits.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the instruction value presented when no valid entry is held.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning stall-counter width.
REQ-005 SHALL run on one clock; reset is synchronous and active-low.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-008 SHALL have port flush, input, 1, discard all held entries (branch redirect).
REQ-009 SHALL have port in_valid, input, 1, fetch offers an entry.
REQ-010 SHALL have port in_ready, output, 1, stage accepts an entry this cycle.
REQ-011 SHALL have ports InstrF [DATA_WIDTH], PCF [ADDR_WIDTH] and PCPlus4F [ADDR_WIDTH], all inputs, carrying the fetch payload.
REQ-012 SHALL have port out_valid, output, 1, decode entry valid.
REQ-013 SHALL have port out_ready, input, 1, decode consumes the entry this cycle.
REQ-014 SHALL have ports InstrD [DATA_WIDTH], PCD [ADDR_WIDTH] and PCPlus4D [ADDR_WIDTH], all outputs, carrying the decode payload.
REQ-015 SHALL have port stall_cnt, output, CNT_WIDTH, saturating count of backpressure cycles.

Function
REQ-016 SHALL hold a main register and a skid register, each with its own valid bit; the state is EMPTY (none valid), ONE (main only) or TWO (main and skid).
REQ-017 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-018 SHALL drive in_ready = !skid_valid, taken from a register with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = main_valid.
REQ-020 SHALL drive InstrD = NOP_INSTR and PCD = PCPlus4D = 0 when main_valid=0, and the main payload otherwise.
REQ-021 EMPTY: on input transfer, SHALL load main and go to ONE.
REQ-022 ONE: on input transfer with output transfer, SHALL reload main and stay in ONE.
REQ-023 ONE: on output transfer only, SHALL go to EMPTY.
REQ-024 ONE: on input transfer only, SHALL load skid and go to TWO.
REQ-025 TWO: on output transfer, SHALL move skid to main, clear skid_valid and go to ONE; no input transfer is possible in TWO.
REQ-026 SHALL give 1-cycle latency: an entry accepted at edge N appears on the outputs after edge N when main is empty or drains at N.
REQ-027 SHALL preserve order; entries are never dropped or duplicated except by flush.
REQ-028 flush=1 SHALL clear both valid bits at the next edge and override any simultaneous input or output transfer (the in_valid entry is dropped); in_ready stays as registered that cycle.
REQ-029 SHALL increment stall_cnt each cycle with out_valid && !out_ready && !flush, saturating at all-ones with no wrap.
REQ-030 flush SHALL NOT clear stall_cnt.
REQ-031 SHALL ignore payload inputs when in_valid=0; payload registers need not reset, but outputs obey REQ-020.

Reset
REQ-032 With reset=0 at a rising edge, SHALL clear main_valid, skid_valid and stall_cnt, with reset overriding flush and all transfers.
REQ-033 After reset SHALL present out_valid=0, in_ready=1, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0 and stall_cnt=0.
REQ-034 Reset asserted mid-operation in TWO SHALL discard both entries, returning to EMPTY at that edge.

Verification
REQ-035 Streaming: out_ready=1, in_valid=1, InstrF=A,B,C at cycles 1-3 -> InstrD=A,B,C at cycles 2-4, in_ready=1 throughout.
REQ-036 Backpressure: out_ready=0, offer A,B,C -> A and B accepted, in_ready=0 from the cycle after B is accepted, C held off; after out_ready=1, outputs A,B,C in order with none lost.
REQ-037 Flush in TWO with in_valid=1 carrying D -> next cycle out_valid=0, InstrD=32'h13, in_ready=1, and D is never output.
REQ-038 Saturation: CNT_WIDTH=4, 20 stall cycles -> stall_cnt=15 and holds at 15.
REQ-039 Reset: reset=0 for one edge while in TWO with stall_cnt=7 -> out_valid=0, in_ready=1, stall_cnt=0, PCD=0.
REQ-040 Randomised in_valid, out_ready and sparse flush against a scoreboard -> order preserved, no loss outside flush, in_ready never combinationally dependent on out_ready.
